// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with per-key sweep debounce.
// Columns are driven one-cold in turn; the row inputs are sampled at the end
// of every column slot. After all four columns are captured, the snapshot is
// debounced, and a single-cycle one-hot press pulse is emitted for the lowest
// newly pressed key.
// The row inputs are expected to come from a pulled-up keypad and to be
// synchronised to clk upstream if the matrix is wired straight to pins.
// Optional feature: define KEYPAD_REPEAT_EN to compile in auto-repeat of a
// single held key (first repeat after REPEAT_DELAY sweeps, then every
// REPEAT_RATE sweeps).

module keypad_scanner #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEB_SWEEPS   = 4,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] key_out,
    output logic [15:0] key_held
);

    localparam int              SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_MAX   = 4'(DEB_SWEEPS);

    // scan state
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [3:0]        col_q, col_d;
    logic [15:0]       snap_q, snap_d;
    logic              eval_q, eval_d;
    logic              sample_s;

    // debounce state
    logic [3:0]        agree_q [16];
    logic [3:0]        agree_d [16];
    logic [15:0]       held_q, held_d;
    logic [15:0]       out_q, out_d;
    logic [15:0]       rise_s;
    logic [15:0]       press_s;
    logic [15:0]       rpt_pulse_s;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;   // 0: waiting first delay, 1: repeating
    logic             one_held_s;
`endif

    // Column slot timing, row sampling into the sweep snapshot, evaluate strobe
    always_comb begin
        slot_d    = slot_q;
        col_idx_d = col_idx_q;
        snap_d    = snap_q;
        eval_d    = 1'b0;
        sample_s  = (slot_q == SLOT_LAST);
        if (sample_s) begin
            slot_d    = '0;
            col_idx_d = col_idx_q + 2'd1;
            eval_d    = (col_idx_q == 2'd3);
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (col_idx_q == 2'(c)) begin
                        snap_d[r*4+c] = ~row[r];
                    end else begin
                        snap_d[r*4+c] = snap_q[r*4+c];
                    end
                end
            end
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end
        col_d = ~(4'b0001 << col_idx_d);
    end

    // Per-key agreement counting and debounced level update on evaluate cycles
    always_comb begin
        held_d = held_q;
        for (int k = 0; k < 16; k++) begin
            agree_d[k] = agree_q[k];
        end
        if (eval_q) begin
            for (int k = 0; k < 16; k++) begin
                if (snap_q[k] != held_q[k]) begin
                    if ((agree_q[k] + 4'd1) >= DEB_MAX) begin
                        held_d[k]  = ~held_q[k];
                        agree_d[k] = 4'd0;
                    end else begin
                        agree_d[k] = agree_q[k] + 4'd1;
                    end
                end else begin
                    agree_d[k] = 4'd0;
                end
            end
        end else begin
            held_d = held_q;
        end
        // only rising keys may pulse; isolate the lowest one
        rise_s  = held_d & ~held_q;
        press_s = rise_s & (~rise_s + 16'd1);
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat timing for a single held key, restarted on any held change
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
        rpt_pulse_s = 16'h0000;
        one_held_s  = (held_q != 16'h0000) && ((held_q & (held_q - 16'd1)) == 16'h0000);
        if (eval_q) begin
            if (held_d != held_q) begin
                rpt_cnt_d   = '0;
                rpt_phase_d = 1'b0;
            end else if (one_held_s) begin
                if (!rpt_phase_q) begin
                    if ((rpt_cnt_q + RPT_W'(1)) == RPT_W'(REPEAT_DELAY)) begin
                        rpt_pulse_s = held_q;
                        rpt_cnt_d   = '0;
                        rpt_phase_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end else begin
                    if ((rpt_cnt_q + RPT_W'(1)) == RPT_W'(REPEAT_RATE)) begin
                        rpt_pulse_s = held_q;
                        rpt_cnt_d   = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
            end else begin
                rpt_cnt_d   = '0;
                rpt_phase_d = 1'b0;
            end
        end else begin
            rpt_cnt_d = rpt_cnt_q;
        end
    end
`else
    // Without auto-repeat, only fresh presses produce pulses
    always_comb begin
        rpt_pulse_s = 16'h0000;
    end
`endif

    // Press pulse output: high only in the cycle after an evaluate cycle
    always_comb begin
        out_d = press_s | rpt_pulse_s;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q    <= '0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
            snap_q    <= 16'h0000;
            eval_q    <= 1'b0;
            held_q    <= 16'h0000;
            out_q     <= 16'h0000;
            for (int k = 0; k < 16; k++) begin
                agree_q[k] <= 4'd0;
            end
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
`endif
        end else begin
            slot_q    <= slot_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            snap_q    <= snap_d;
            eval_q    <= eval_d;
            held_q    <= held_d;
            out_q     <= out_d;
            for (int k = 0; k < 16; k++) begin
                agree_q[k] <= agree_d[k];
            end
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
`endif
        end
    end

    assign col      = col_q;
    assign key_out  = out_q;
    assign key_held = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4,
// DEB_SWEEPS=2 (one sweep = 16 clocks). Cycle numbering restarts at 0 on the
// first cycle after reset is released; sweep n is evaluated in cycle 16n and
// its debounced result / press pulse is visible in cycle 16n+1.

module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] key_out;
    logic [15:0] key_held;

    logic [15:0] keys = 16'h0000;   // physically pressed keys
    int          cyc  = 0;
    int          checks = 0;
    int          errors = 0;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEB_SWEEPS   (2),
        .REPEAT_DELAY (4),
        .REPEAT_RATE  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_out  (key_out),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // keypad matrix: row r is pulled low when key r*4+c is pressed and column c is driven low
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(keys[r*4 +: 4] & ~col);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [15:0] k);
        keys = k;
        rst  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    logic [3:0]  exp_col;
    logic [15:0] exp_held;
    logic [15:0] exp_out;

    initial begin
        // reset state and column order
        do_reset(16'h0000);
        chk("rst_col", {12'h000, col}, 16'h000E);
        chk("rst_out", key_out, 16'h0000);
        chk("rst_held", key_held, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            exp_col = 4'b1111;
            exp_col[(i / 4) % 4] = 1'b0;
            chk("col_seq", {12'h000, col}, {12'h000, exp_col});
            chk("idle_out", key_out, 16'h0000);
            tick();
        end

        // key 5 held from reset, released at start of sweep 4
        do_reset(16'h0020);
        while (cyc < 100) begin
            if (cyc == 48) keys = 16'h0000;
            exp_held = (cyc >= 33 && cyc < 81) ? 16'h0020 : 16'h0000;
            exp_out  = (cyc == 33) ? 16'h0020 : 16'h0000;
            chk("k5_held", key_held, exp_held);
            chk("k5_out", key_out, exp_out);
            tick();
        end

        // key 5 bounce lasting one sweep only
        do_reset(16'h0020);
        while (cyc < 80) begin
            if (cyc == 16) keys = 16'h0000;
            chk("short_held", key_held, 16'h0000);
            chk("short_out", key_out, 16'h0000);
            tick();
        end

        // keys 2 and 9 together: lowest index pulses, both held
        do_reset(16'h0204);
        while (cyc < 60) begin
            exp_held = (cyc >= 33) ? 16'h0204 : 16'h0000;
            exp_out  = (cyc == 33) ? 16'h0004 : 16'h0000;
            chk("two_held", key_held, exp_held);
            chk("two_out", key_out, exp_out);
            tick();
        end

        // reset mid-sweep (slot 2 of column 2 in sweep 3) with key 5 held
        do_reset(16'h0020);
        while (cyc < 42) begin
            exp_held = (cyc >= 33) ? 16'h0020 : 16'h0000;
            chk("pre_rst_held", key_held, exp_held);
            tick();
        end
        rst = 1'b1;
        tick();
        chk("mid_rst_col", {12'h000, col}, 16'h000E);
        chk("mid_rst_held", key_held, 16'h0000);
        chk("mid_rst_out", key_out, 16'h0000);
        rst = 1'b0;
        cyc = 0;
        while (cyc < 40) begin
            exp_held = (cyc >= 33) ? 16'h0020 : 16'h0000;
            exp_out  = (cyc == 33) ? 16'h0020 : 16'h0000;
            exp_col  = 4'b1111;
            exp_col[(cyc / 4) % 4] = 1'b0;
            chk("requal_held", key_held, exp_held);
            chk("requal_out", key_out, exp_out);
            chk("requal_col", {12'h000, col}, {12'h000, exp_col});
            tick();
        end

        // key 0 held for 12 sweeps: repeat pulses only when the feature is built in
        do_reset(16'h0001);
        while (cyc < 240) begin
            if (cyc == 192) keys = 16'h0000;
            exp_held = (cyc >= 33 && cyc < 225) ? 16'h0001 : 16'h0000;
`ifdef KEYPAD_REPEAT_EN
            exp_out = (cyc == 33 || cyc == 97 || cyc == 129 || cyc == 161 || cyc == 193)
                      ? 16'h0001 : 16'h0000;
`else
            exp_out = (cyc == 33) ? 16'h0001 : 16'h0000;
`endif
            chk("rpt_held", key_held, exp_held);
            chk("rpt_out", key_out, exp_out);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
